// File: rtl/stat_accumulator_if.sv
// rtl/stat_accumulator_if.sv - sample/result bundle between the statistics engine and its driver
interface stat_accumulator_if #(
  parameter int WIDTH = 8
);
  logic             START;
  logic             DATA_valid;
  logic [WIDTH-1:0] DATA_in;
  logic             LAST;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] MAX_out;
  logic [WIDTH-1:0] MIN_out;
  logic [WIDTH-1:0] AVG_out;
  logic             FLAG_bit;
  logic             FLAG_load;

  modport master (
    output START, DATA_valid, DATA_in, LAST,
    input  BUSY, DONE, MAX_out, MIN_out, AVG_out, FLAG_bit, FLAG_load
  );

  modport slave (
    input  START, DATA_valid, DATA_in, LAST,
    output BUSY, DONE, MAX_out, MIN_out, AVG_out, FLAG_bit, FLAG_load
  );
endinterface

// File: rtl/stat_accumulator.sv
// rtl/stat_accumulator.sv - burst max/min/sum tracker with bit-serial restoring floor-average divider
module stat_accumulator #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  stat_accumulator_if.slave bus
);
  localparam int SUM_W  = WIDTH + COUNT_W;
  localparam int STEP_W = $clog2(SUM_W + 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SUM_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DIVIDE,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   run_max_q, run_max_d;
  logic [WIDTH-1:0]   run_min_q, run_min_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [SUM_W-1:0]   quo_q, quo_d;
  logic [COUNT_W-1:0] rem_q, rem_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [WIDTH-1:0]   max_q, max_d;
  logic [WIDTH-1:0]   min_q, min_d;
  logic [WIDTH-1:0]   avg_q, avg_d;
  logic [COUNT_W:0]   trial;
  logic               accept;
  logic               flag_bit;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      run_max_q <= '0;
      run_min_q <= '0;
      sum_q     <= '0;
      count_q   <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      step_q    <= '0;
      max_q     <= '0;
      min_q     <= '0;
      avg_q     <= '0;
    end else begin
      state_q   <= state_d;
      run_max_q <= run_max_d;
      run_min_q <= run_min_d;
      sum_q     <= sum_d;
      count_q   <= count_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      step_q    <= step_d;
      max_q     <= max_d;
      min_q     <= min_d;
      avg_q     <= avg_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    run_max_d = run_max_q;
    run_min_d = run_min_q;
    sum_d     = sum_q;
    count_d   = count_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    step_d    = step_q;
    max_d     = max_q;
    min_d     = min_q;
    avg_d     = avg_q;
    trial     = '0;
    accept    = 1'b0;
    flag_bit  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          state_d   = S_ACCUM;
          run_max_d = '0;
          run_min_d = '1;
          sum_d     = '0;
          count_d   = '0;
        end
      end
      S_ACCUM: begin
        if (bus.DATA_valid) begin
          // A saturated counter drops the sample but still lets LAST close the burst
          if (count_q != {COUNT_W{1'b1}}) begin
            accept   = 1'b1;
            flag_bit = (bus.DATA_in > run_max_q);
            if (bus.DATA_in > run_max_q) run_max_d = bus.DATA_in;
            if (bus.DATA_in < run_min_q) run_min_d = bus.DATA_in;
            sum_d   = sum_q + {{COUNT_W{1'b0}}, bus.DATA_in};
            count_d = count_q + COUNT_W'(1);
          end
          if (bus.LAST) begin
            state_d = S_DIVIDE;
            quo_d   = sum_d;
            rem_d   = '0;
            step_d  = '0;
          end
        end
      end
      S_DIVIDE: begin
        if (step_q == LAST_STEP) begin
          state_d = S_DONE;
          max_d   = run_max_q;
          min_d   = run_min_q;
          avg_d   = quo_q[WIDTH-1:0];
        end else begin
          // quo_q shifts the dividend out of its top while quotient bits enter at the bottom
          trial = {rem_q, quo_q[SUM_W-1]};
          if (trial >= {1'b0, count_q}) begin
            rem_d = trial[COUNT_W-1:0] - count_q;
            quo_d = {quo_q[SUM_W-2:0], 1'b1};
          end else begin
            rem_d = trial[COUNT_W-1:0];
            quo_d = {quo_q[SUM_W-2:0], 1'b0};
          end
          step_d = step_q + STEP_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.BUSY      = (state_q != S_IDLE);
  assign bus.DONE      = (state_q == S_DONE);
  assign bus.MAX_out   = max_q;
  assign bus.MIN_out   = min_q;
  assign bus.AVG_out   = avg_q;
  assign bus.FLAG_load = accept;
  assign bus.FLAG_bit  = flag_bit;
endmodule

// File: tb/tb_stat_accumulator.sv
// tb/tb_stat_accumulator.sv - randomized and directed self-checking bench for stat_accumulator
module tb_stat_accumulator;
  localparam int WIDTH   = 8;
  localparam int SAT_CNT = 255;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  bit   in_accum;
  int   m_max;
  int   m_cnt;
  int   flag_q[$];
  int   none[$];

  stat_accumulator_if #(.WIDTH(WIDTH)) ifc ();

  stat_accumulator #(.WIDTH(WIDTH), .COUNT_W(8)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Flag strobes predicted from the running maximum of the samples accepted so far
  always @(negedge clk) begin
    bit exp_load;
    bit exp_bit;
    exp_load = in_accum && (ifc.DATA_valid === 1'b1) && (m_cnt < SAT_CNT);
    exp_bit  = exp_load && (int'(ifc.DATA_in) > m_max);
    check("flag_load", ifc.FLAG_load, exp_load);
    check("flag_bit", ifc.FLAG_bit, exp_bit);
    if (ifc.FLAG_load === 1'b1) flag_q.push_back(int'(ifc.FLAG_bit));
    if (exp_load) begin
      if (int'(ifc.DATA_in) > m_max) m_max = int'(ifc.DATA_in);
      m_cnt++;
    end
  end

  task automatic run_burst(input int s[$], input bit gaps, input bit stray,
                           input int e_max, input int e_min, input int e_avg,
                           input int e_flags[$], input int e_loads);
    int n_acc, mx, mn, sm, n;
    bit seen;
    n_acc = (s.size() > SAT_CNT) ? SAT_CNT : s.size();
    mx = 0;
    mn = 255;
    sm = 0;
    for (int i = 0; i < n_acc; i++) begin
      if (s[i] > mx) mx = s[i];
      if (s[i] < mn) mn = s[i];
      sm += s[i];
    end
    if (e_max >= 0) check("model_max", mx, e_max);
    if (e_min >= 0) check("model_min", mn, e_min);
    if (e_avg >= 0) check("model_avg", sm / n_acc, e_avg);
    flag_q.delete();

    @(posedge clk); #1;
    ifc.START = 1'b1;
    @(posedge clk); #1;
    ifc.START = 1'b0;
    m_max = 0;
    m_cnt = 0;
    in_accum = 1'b1;
    check("busy_after_start", ifc.BUSY, 1);

    for (int i = 0; i < s.size(); i++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        repeat ($urandom_range(1, 3)) begin
          ifc.DATA_valid = 1'b0;
          ifc.LAST       = 1'($urandom_range(0, 1));
          ifc.DATA_in    = 8'($urandom_range(0, 255));
          ifc.START      = stray;
          @(posedge clk); #1;
        end
      end
      ifc.DATA_valid = 1'b1;
      ifc.DATA_in    = 8'(s[i]);
      ifc.LAST       = (i == s.size() - 1);
      ifc.START      = stray && (i % 2 == 1);
      @(posedge clk); #1;
    end
    ifc.DATA_valid = 1'b0;
    ifc.LAST       = 1'b0;
    ifc.DATA_in    = '0;
    ifc.START      = 1'b0;
    in_accum       = 1'b0;
    check("busy_after_last", ifc.BUSY, 1);

    seen = 1'b0;
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ifc.DONE === 1'b1) begin
        seen = 1'b1;
        break;
      end
      ifc.START = stray;
    end
    ifc.START = 1'b0;
    check("done_seen", seen, 1);
    check("done_latency", n, 17);
    check("max_out", ifc.MAX_out, mx);
    check("min_out", ifc.MIN_out, mn);
    check("avg_out", ifc.AVG_out, sm / n_acc);
    check("flag_strobes", flag_q.size(), n_acc);
    if (e_loads >= 0) check("flag_strobes_lit", flag_q.size(), e_loads);
    if (e_flags.size() > 0) begin
      for (int i = 0; i < e_flags.size(); i++)
        check("flag_pattern", (i < flag_q.size()) ? flag_q[i] : -1, e_flags[i]);
    end
    @(negedge clk);
    check("done_one_cycle", ifc.DONE, 0);
    check("busy_fall", ifc.BUSY, 0);
  endtask

  task automatic reset_mid_divide();
    int dones;
    @(posedge clk); #1;
    ifc.START = 1'b1;
    @(posedge clk); #1;
    ifc.START = 1'b0;
    m_max = 0;
    m_cnt = 0;
    in_accum = 1'b1;
    ifc.DATA_valid = 1'b1;
    ifc.DATA_in    = 8'd50;
    @(posedge clk); #1;
    ifc.DATA_in    = 8'd60;
    ifc.LAST       = 1'b1;
    @(posedge clk); #1;
    ifc.DATA_valid = 1'b0;
    ifc.LAST       = 1'b0;
    in_accum       = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rst_busy", ifc.BUSY, 0);
    check("rst_done", ifc.DONE, 0);
    check("rst_max", ifc.MAX_out, 0);
    check("rst_min", ifc.MIN_out, 0);
    check("rst_avg", ifc.AVG_out, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    dones = 0;
    repeat (30) begin
      @(negedge clk);
      if (ifc.DONE === 1'b1) dones++;
    end
    check("rst_no_done", dones, 0);
  endtask

  initial begin
    int s[$];
    int f[$];
    checks   = 0;
    failures = 0;
    in_accum = 1'b0;
    m_max    = 0;
    m_cnt    = 0;
    rst            = 1'b1;
    ifc.START      = 1'b0;
    ifc.DATA_valid = 1'b0;
    ifc.DATA_in    = '0;
    ifc.LAST       = 1'b0;
    #2;
    check("reset_busy", ifc.BUSY, 0);
    check("reset_done", ifc.DONE, 0);
    check("reset_max", ifc.MAX_out, 0);
    check("reset_min", ifc.MIN_out, 0);
    check("reset_avg", ifc.AVG_out, 0);
    check("reset_flag_load", ifc.FLAG_load, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    s = '{30, 10, 40, 20};
    f = '{1, 0, 1, 0};
    run_burst(s, 1'b0, 1'b0, 40, 10, 25, f, 4);
    s = '{5, 5, 5};
    f = '{1, 0, 0};
    run_burst(s, 1'b0, 1'b0, 5, 5, 5, f, 3);
    s = '{1, 2};
    run_burst(s, 1'b0, 1'b0, 2, 1, 1, none, 2);
    s = '{0};
    f = '{0};
    run_burst(s, 1'b0, 1'b0, 0, 0, 0, f, 1);
    s.delete();
    for (int i = 0; i < 300; i++) s.push_back(255);
    run_burst(s, 1'b0, 1'b0, 255, 255, 255, none, 255);
    s = '{30, 10, 40, 20};
    f = '{1, 0, 1, 0};
    run_burst(s, 1'b1, 1'b1, 40, 10, 25, f, 4);

    for (int b = 0; b < 8; b++) begin
      s.delete();
      repeat ($urandom_range(1, 20)) s.push_back(int'($urandom_range(0, 255)));
      run_burst(s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, -1, -1, none, -1);
    end

    reset_mid_divide();
    s = '{7, 9};
    f = '{1, 1};
    run_burst(s, 1'b0, 1'b0, 9, 7, 8, f, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/stat_accumulator.md
# stat_accumulator

- Sequential statistics engine in the ASIP datapath, directly upstream of the one-bit flag flip-flop.
- Accepts a burst of unsigned samples and tracks running maximum, minimum and sum.
- Computes the floor average with a bit-serial restoring divider.
- On every accepted sample, drives a one-cycle load strobe and a "new maximum" bit to the flag flip-flop.

## Interface
- WIDTH, 8, sample and result width in bits
- COUNT_W, 8, sample-counter width; max 2^COUNT_W-1 samples per burst
- Derived SUM_W = WIDTH+COUNT_W, accumulator width and divider iteration count
- CLK  input  1  clock; all state changes on rising edge
- RESET  input  1  one clock; reset is asynchronous and active-high
- START  input  1  begin burst; honoured only in IDLE
- DATA_valid  input  1  DATA_in carries a sample this cycle
- DATA_in  input  WIDTH  unsigned sample
- LAST  input  1  qualifies final sample; honoured only with DATA_valid in ACCUM
- BUSY  output  1  high in ACCUM, DIVIDE and DONE states
- DONE  output  1  one-cycle pulse when results are valid
- MAX_out  output  WIDTH  maximum of the last completed burst
- MIN_out  output  WIDTH  minimum of the last completed burst
- AVG_out  output  WIDTH  floor(sum/count) of the last completed burst
- FLAG_bit  output  1  sample strictly greater than the running maximum; goes to flip-flop BIT_in
- FLAG_load  output  1  one-cycle strobe per accumulated sample; goes to flip-flop FF_load

## Operation
- FSM states: IDLE -> ACCUM -> DIVIDE -> DONE -> IDLE.
- IDLE:
  - START=1 clears run_max=0, run_min=all ones, sum=0, count=0, then enters ACCUM.
  - Other inputs are ignored.
- ACCUM, each cycle with DATA_valid=1 and count < 2^COUNT_W-1:
  - run_max=max(run_max,DATA_in), run_min=min(run_min,DATA_in), sum+=DATA_in (zero-extended), count+=1.
  - FLAG_load=1 and FLAG_bit=(DATA_in > run_max before update) in the same cycle, combinational from inputs and state. Equality gives 0.
- Counter saturated: a sample with count = 2^COUNT_W-1 is not accumulated and FLAG_load stays 0. Its LAST is still honoured.
- DATA_valid=1 with LAST=1 accumulates that sample (unless saturated) and enters DIVIDE. LAST without DATA_valid is ignored.
- START while not in IDLE is ignored.
- DIVIDE:
  - Restoring division of sum by count, one quotient bit per cycle, MSB first, SUM_W cycles.
  - count is never 0 here, because LAST always carries a sample.
  - The quotient is at most run_max, so its low WIDTH bits are exact.
- DONE:
  - On the edge entering DONE, MAX_out, MIN_out and AVG_out load from run_max, run_min and the quotient.
  - DONE=1 for exactly one cycle, then IDLE.
  - Result outputs hold until the next DONE entry.
- FLAG_bit=0 whenever FLAG_load=0.
- Reset (asynchronous, any state): FSM to IDLE; all registers and outputs 0. This gives BUSY=0, DONE=0, MAX_out=MIN_out=AVG_out=0, FLAG_load=0, FLAG_bit=0.
- Reset mid-DIVIDE or mid-ACCUM aborts the burst with no DONE pulse.

## Timing
- START accepted on edge e: BUSY high from e; the first sample is accepted no earlier than edge e+1.
- Sample throughput is one per cycle, with no back-pressure.
- LAST accepted on edge L:
  - Division steps occur on edges L+1 .. L+SUM_W.
  - DONE is high in the cycle following edge L+SUM_W+1 (17 cycles after L for the defaults).
  - Results are valid in that same cycle.
- BUSY falls on the edge after the DONE cycle. START may be accepted in the first IDLE cycle.
- FLAG_load/FLAG_bit are valid in the cycle of the sample, so the flip-flop captures them on the sample's accepting edge.

## Test plan
- Reset then START, then samples 30,10,40,20 with LAST on 20 -> FLAG_bit pattern 1,0,1,0 on four FLAG_load strobes; DONE 17 cycles after LAST; MAX_out=40, MIN_out=10, AVG_out=25.
- Samples 5,5,5 -> FLAG pattern 1,0,0 (strict compare); MAX=MIN=AVG=5.
- Samples 1,2 -> AVG_out=1 (floor). Single sample 0 with LAST -> FLAG_bit=0, MAX=MIN=AVG=0.
- 300 samples of 255 with LAST on the 300th:
  - Exactly 255 FLAG_load strobes.
  - Samples 256..300 are ignored; DONE still fires.
  - MAX=MIN=AVG=255.
- START pulsed during ACCUM and DIVIDE -> no effect on results. Gaps in DATA_valid -> same results as a contiguous burst.
- RESET asserted mid-DIVIDE -> all outputs 0 immediately, no DONE pulse. A new burst (7,9) then yields MAX=9, MIN=7, AVG=8.
